// File: rtl/l2_mem_arbiter.sv
// rtl/l2_mem_arbiter.sv - round-robin L1I/L1D arbiter for the line-granular memory port
// Optional watchdog: define L2_MEM_ARB_TIMEOUT_EN.
module l2_mem_arbiter #(
  parameter int LINE_W         = 512,
  parameter int INDEX_W        = 8,
  parameter int TAG_W          = 18,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_read,
  input  logic [INDEX_W-1:0] i_index,
  input  logic [TAG_W-1:0]   i_tag,
  output logic               i_ready,
  output logic [LINE_W-1:0]  i_rdata,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [INDEX_W-1:0] d_index,
  input  logic [TAG_W-1:0]   d_tag,
  input  logic [TAG_W-1:0]   d_wtag,
  input  logic [LINE_W-1:0]  d_wdata,
  output logic               d_ready,
  output logic [LINE_W-1:0]  d_rdata,
  output logic               mem_read,
  output logic               mem_write,
  output logic [INDEX_W-1:0] mem_index,
  output logic [TAG_W-1:0]   mem_tag,
  output logic [LINE_W-1:0]  mem_wdata,
  input  logic               mem_ready,
  input  logic [LINE_W-1:0]  mem_rdata,
  output logic               mem_err
);

  typedef enum logic [2:0] {IDLE, I_RD, D_WB, D_RD, RESP_I, RESP_D} state_t;

  state_t             state_q, state_d;
  logic               rr_last_q, rr_last_d;  // 1: D won the last grant
  logic               d_rd_q, d_rd_d;
  logic [TAG_W-1:0]   d_tag_q, d_tag_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [INDEX_W-1:0] mem_index_q, mem_index_d;
  logic [TAG_W-1:0]   mem_tag_q, mem_tag_d;
  logic [LINE_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               i_ready_q, i_ready_d;
  logic               d_ready_q, d_ready_d;
  logic [LINE_W-1:0]  i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0]  d_rdata_q, d_rdata_d;

`ifdef L2_MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 2);
  logic [15:0] wdog_q, wdog_d;
  logic        mem_err_q, mem_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    d_rd_d      = d_rd_q;
    d_tag_d     = d_tag_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_index_d = mem_index_q;
    mem_tag_d   = mem_tag_q;
    mem_wdata_d = mem_wdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (i_read && (!(d_read || d_write) || rr_last_q)) begin
          state_d     = I_RD;
          rr_last_d   = 1'b0;
          mem_read_d  = 1'b1;
          mem_index_d = i_index;
          mem_tag_d   = i_tag;
        end else if (d_read || d_write) begin
          rr_last_d   = 1'b1;
          mem_index_d = d_index;
          d_tag_d     = d_tag;
          d_rd_d      = d_read;
          if (d_write) begin
            state_d     = D_WB;
            mem_write_d = 1'b1;
            mem_tag_d   = d_wtag;
            mem_wdata_d = d_wdata;
          end else begin
            state_d    = D_RD;
            mem_read_d = 1'b1;
            mem_tag_d  = d_tag;
          end
        end
      end
      I_RD: begin
        if (mem_ready) begin
          i_rdata_d  = mem_rdata;
          mem_read_d = 1'b0;
          i_ready_d  = 1'b1;
          state_d    = RESP_I;
        end
      end
      D_WB: begin
        if (mem_ready) begin
          mem_write_d = 1'b0;
          if (d_rd_q) begin
            // Entering D_RD with mem_read still low yields the one-cycle gap.
            state_d   = D_RD;
            mem_tag_d = d_tag_q;
          end else begin
            state_d   = RESP_D;
            d_ready_d = 1'b1;
          end
        end
      end
      D_RD: begin
        if (!mem_read_q) begin
          mem_read_d = 1'b1;
        end else if (mem_ready) begin
          d_rdata_d  = mem_rdata;
          mem_read_d = 1'b0;
          d_ready_d  = 1'b1;
          state_d    = RESP_D;
        end
      end
      RESP_I:  state_d = IDLE;
      RESP_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef L2_MEM_ARB_TIMEOUT_EN
    wdog_d    = wdog_q;
    mem_err_d = 1'b0;
    if (state_q == IDLE) begin
      wdog_d = '0;
    end else if (mem_read_q || mem_write_q) begin
      wdog_d = wdog_q + 16'd1;
      if (!mem_ready && wdog_q == WDOG_LAST) begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_err_d   = 1'b1;
        state_d     = IDLE;
        if (state_q == I_RD) i_ready_d = 1'b1;
        else                 d_ready_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_last_q   <= 1'b1;
      d_rd_q      <= 1'b0;
      d_tag_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_index_q <= '0;
      mem_tag_q   <= '0;
      mem_wdata_q <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      d_rd_q      <= d_rd_d;
      d_tag_q     <= d_tag_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_index_q <= mem_index_d;
      mem_tag_q   <= mem_tag_d;
      mem_wdata_q <= mem_wdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

`ifdef L2_MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;
`else
  assign mem_err = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_index = mem_index_q;
  assign mem_tag   = mem_tag_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// tb/tb_l2_mem_arbiter.sv - scoreboard bench for l2_mem_arbiter
// Requester/memory models push and pop expected memory ops and ready responses.
module tb_l2_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_read = 1'b0;
  logic [7:0]   i_index = '0;
  logic [17:0]  i_tag = '0;
  logic         i_ready;
  logic [511:0] i_rdata;
  logic         d_read = 1'b0;
  logic         d_write = 1'b0;
  logic [7:0]   d_index = '0;
  logic [17:0]  d_tag = '0;
  logic [17:0]  d_wtag = '0;
  logic [511:0] d_wdata = '0;
  logic         d_ready;
  logic [511:0] d_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [7:0]   mem_index;
  logic [17:0]  mem_tag;
  logic [511:0] mem_wdata;
  logic         mem_ready = 1'b0;
  logic [511:0] mem_rdata = '0;
  logic         mem_err;

  l2_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_index(i_index), .i_tag(i_tag), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_index(d_index), .d_tag(d_tag), .d_wtag(d_wtag),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_index(mem_index), .mem_tag(mem_tag),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] idx; logic [17:0] tag; logic [17:0] wtag; logic [511:0] wdata; bit rd; bit wr;} req_t;
  typedef struct {bit wr; logic [7:0] idx; logic [17:0] tag; logic [511:0] wdata; int gap;} mop_t;
  typedef struct {bit is_d; logic [511:0] data;} resp_t;

  req_t  iq[$];
  req_t  dq[$];
  mop_t  exp_mem[$];
  resp_t exp_resp[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 1;
  int i_raise_cyc = 0, d_raise_cyc = 0, i_lat = 0, d_lat = 0;
  int start_cyc = 0, idle_cnt = 100, mem_cnt = 0, overlap = 0, err_seen = 0;
  bit mem_busy = 0;
  req_t ri, rd;
  mop_t mo;
  resp_t ro;

  localparam logic [511:0] W1 = {16{32'h1234_5678}};
  localparam logic [511:0] W2 = {16{32'hDEAD_BEEF}};

  function automatic logic [511:0] line_of(input logic [17:0] tag);
    return {16{32'hAAAA_AAAA ^ {14'd0, tag}}};
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_i(input logic [7:0] idx, input logic [17:0] tag);
    req_t r;
    r.idx = idx; r.tag = tag; r.wtag = '0; r.wdata = '0; r.rd = 1; r.wr = 0;
    iq.push_back(r);
  endtask

  task automatic push_d(input logic [7:0] idx, input logic [17:0] tag, input logic [17:0] wtag,
                        input logic [511:0] wdata, input bit rd_en, input bit wr_en);
    req_t r;
    r.idx = idx; r.tag = tag; r.wtag = wtag; r.wdata = wdata; r.rd = rd_en; r.wr = wr_en;
    dq.push_back(r);
  endtask

  task automatic exp_op(input bit wr, input logic [7:0] idx, input logic [17:0] tag,
                        input logic [511:0] wdata, input int gap);
    mop_t m;
    m.wr = wr; m.idx = idx; m.tag = tag; m.wdata = wdata; m.gap = gap;
    exp_mem.push_back(m);
  endtask

  task automatic exp_rsp(input bit is_d, input logic [511:0] data);
    resp_t r;
    r.is_d = is_d; r.data = data;
    exp_resp.push_back(r);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (n < 300 && !(iq.size() == 0 && dq.size() == 0 && !i_read && !d_read && !d_write &&
                        exp_resp.size() == 0 && exp_mem.size() == 0)) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending responses, expected 0", name, exp_resp.size());
    end
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Requesters: drop on ready, raise the next queued request the following cycle
  always @(negedge clk) begin
    if (i_ready) begin
      i_read = 1'b0;
    end else if (!i_read && iq.size() > 0) begin
      ri = iq.pop_front();
      i_index = ri.idx; i_tag = ri.tag; i_read = 1'b1;
      i_raise_cyc = cyc;
    end
    if (d_ready) begin
      d_read = 1'b0; d_write = 1'b0;
    end else if (!d_read && !d_write && dq.size() > 0) begin
      rd = dq.pop_front();
      d_index = rd.idx; d_tag = rd.tag; d_wtag = rd.wtag; d_wdata = rd.wdata;
      d_read = rd.rd; d_write = rd.wr;
      d_raise_cyc = cyc;
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (!rst && (i_ready || d_ready)) begin
      if (i_ready && d_ready) chk("both_ready", 1'b1, 1'b0);
      if (exp_resp.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ready: got i_ready=%0b d_ready=%0b, expected none", i_ready, d_ready);
      end else begin
        ro = exp_resp.pop_front();
        chk("resp_side", d_ready, ro.is_d);
        chk("resp_data", d_ready ? d_rdata : i_rdata, ro.data);
        if (d_ready) d_lat = cyc - d_raise_cyc;
        else         i_lat = cyc - i_raise_cyc;
      end
    end
  end

  // Memory model and memory-side scoreboard
  always @(negedge clk) begin
    if (mem_read && mem_write) overlap++;
    if (mem_err) err_seen++;
    if (rst) begin
      mem_busy = 0; mem_ready = 1'b0;
    end else begin
      if (mem_ready) mem_ready = 1'b0;
      if (!(mem_read || mem_write)) begin
        mem_busy = 0;
        idle_cnt++;
      end else begin
        if (!mem_busy) begin
          mem_busy = 1; mem_cnt = 0; start_cyc = cyc;
          if (exp_mem.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_mem_op: got read=%0b write=%0b tag=%0h, expected none", mem_read, mem_write, mem_tag);
          end else begin
            mo = exp_mem.pop_front();
            chk("mem_op", {mem_write, mem_read, mem_index, mem_tag}, {mo.wr, !mo.wr, mo.idx, mo.tag});
            if (mo.wr) chk("mem_wdata", mem_wdata, mo.wdata);
            if (mo.gap >= 0) chk("wb_gap", idle_cnt, mo.gap);
          end
        end
        mem_cnt++;
        if (mem_cnt == mem_lat) begin
          mem_ready = 1'b1;
          mem_rdata = line_of(mem_tag);
        end
        idle_cnt = 0;
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctrl", {mem_read, mem_write, mem_err, i_ready, d_ready, mem_index, mem_tag}, '0);
    chk("reset_data", i_rdata | d_rdata | mem_wdata, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single I refill, memory answers after 4 cycles
    mem_lat = 4;
    push_i(8'h12, 18'h3);
    exp_op(0, 8'h12, 18'h3, '0, -1);
    exp_rsp(0, line_of(18'h3));
    wait_idle("t1");
    chk("t1_strobe_latency", start_cyc - i_raise_cyc, 1);
    chk("t1_ready_latency", i_lat, 5);

    // Sustained contention after an I grant alternates D, I, D, I
    mem_lat = 2;
    push_i(8'h21, 18'h101); push_i(8'h22, 18'h102);
    push_d(8'h31, 18'h201, '0, '0, 1, 0); push_d(8'h32, 18'h202, '0, '0, 1, 0);
    exp_op(0, 8'h31, 18'h201, '0, -1); exp_rsp(1, line_of(18'h201));
    exp_op(0, 8'h21, 18'h101, '0, -1); exp_rsp(0, line_of(18'h101));
    exp_op(0, 8'h32, 18'h202, '0, -1); exp_rsp(1, line_of(18'h202));
    exp_op(0, 8'h22, 18'h102, '0, -1); exp_rsp(0, line_of(18'h102));
    wait_idle("t2");

    // Dirty write-back followed by refill, one-cycle memory
    mem_lat = 1;
    push_d(8'h40, 18'h9, 18'h5, W1, 1, 1);
    exp_op(1, 8'h40, 18'h5, W1, -1);
    exp_op(0, 8'h40, 18'h9, '0, 1);
    exp_rsp(1, line_of(18'h9));
    wait_idle("t3");
    chk("t3_wb_refill_latency", d_lat, 4);

    // Write-back only: d_rdata keeps the previous refill line
    mem_lat = 2;
    push_d(8'h41, 18'h0, 18'h7, W2, 0, 1);
    exp_op(1, 8'h41, 18'h7, W2, -1);
    exp_rsp(1, line_of(18'h9));
    wait_idle("t4");
    chk("t4_wb_latency", d_lat, 3);

    // Reset asserted while D_RD waits on a slow memory
    mem_lat = 30;
    push_d(8'h50, 18'h11, '0, '0, 1, 0);
    exp_op(0, 8'h50, 18'h11, '0, -1);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_ctrl", {mem_read, mem_write, mem_err, i_ready, d_ready, mem_index, mem_tag}, '0);
    chk("async_reset_data", i_rdata | d_rdata | mem_wdata, '0);
    d_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Simultaneous requests after reset: I wins the first tie
    mem_lat = 1;
    push_i(8'h60, 18'h33);
    push_d(8'h61, 18'h44, '0, '0, 1, 0);
    exp_op(0, 8'h60, 18'h33, '0, -1); exp_rsp(0, line_of(18'h33));
    exp_op(0, 8'h61, 18'h44, '0, -1); exp_rsp(1, line_of(18'h44));
    wait_idle("t6");
    chk("t6_i_latency", i_lat, 2);
    chk("t6_d_latency", d_lat, 5);

    repeat (3) @(posedge clk);
    chk("no_strobe_overlap", overlap, 0);
    chk("mem_err_quiet", err_seen, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
